// File: rtl/fp_add_pkg.sv
// Shared types and constants for the FP32 add/sub issue stage.
package fp_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } issue_state_t;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP32_PINF = 32'h7F800000;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
  } fp_pair_t;

endpackage

// File: rtl/fp_pair_fifo.sv
// Show-ahead synchronous FIFO holding {op, a, b} operand pairs.
module fp_pair_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_en;
  logic             w_pop_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_en = i_push & ~o_full;
  assign w_pop_en  = i_pop & ~o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/fp_add_issue.sv
// Operand issue / result capture around the FP32 add/sub unit.
// Optional watchdog compiled in with `define FP_ISSUE_TIMEOUT_EN.
module fp_add_issue
  import fp_add_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_op,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_op,
  output logic        add_en,
  input  logic        add_done_tick,
  input  logic        add_nan,
  input  logic        add_inf,
  input  logic [31:0] add_o,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_nan,
  output logic        out_inf,
  output logic        out_err,
  output logic        busy
);

  issue_state_t r_state;
  fp_pair_t     w_wr_pair;
  fp_pair_t     w_rd_pair;
  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_wd_expire;
  logic [31:0]  r_add_a;
  logic [31:0]  r_add_b;
  logic         r_add_op;
  logic [31:0]  r_result;
  logic         r_nan;
  logic         r_inf;
  logic         r_err;

  assign w_wr_pair = '{op: in_op, a: in_a, b: in_b};
  assign w_pop     = (r_state == ST_IDLE) & ~w_empty;

  fp_pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fp_pair_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (in_valid),
    .i_wdata (w_wr_pair),
    .i_pop   (w_pop),
    .o_rdata (w_rd_pair),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef FP_ISSUE_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] r_wd;

  // Expires on the TIMEOUT-th WAIT cycle that has no done_tick.
  assign w_wd_expire = (r_state == ST_WAIT) && (r_wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd <= '0;
    end else if (w_pop) begin
      r_wd <= '0;
    end else if ((r_state == ST_WAIT) && !add_done_tick && !w_wd_expire) begin
      r_wd <= r_wd + 1'b1;
    end
  end
`else
  assign w_wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_add_a  <= '0;
      r_add_b  <= '0;
      r_add_op <= OP_ADD;
      r_result <= '0;
      r_nan    <= 1'b0;
      r_inf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_add_a  <= w_rd_pair.a;
            r_add_b  <= w_rd_pair.b;
            r_add_op <= w_rd_pair.op;
            r_nan    <= 1'b0;
            r_inf    <= 1'b0;
            r_err    <= 1'b0;
            r_state  <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_nan <= r_nan | add_nan;
          r_inf <= r_inf | add_inf;
          if (add_done_tick) begin
            r_result <= add_o;
            r_state  <= ST_HOLD;
          end else if (w_wd_expire) begin
            r_result <= FP32_QNAN;
            r_err    <= 1'b1;
            r_state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = ~w_full;
  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign add_op     = r_add_op;
  assign add_en     = (r_state == ST_LAUNCH);
  assign out_valid  = (r_state == ST_HOLD);
  assign out_result = r_result;
  assign out_nan    = r_nan;
  assign out_inf    = r_inf;
  assign out_err    = r_err;
  assign busy       = (r_state != ST_IDLE) | ~w_empty;

endmodule

// File: tb/tb_fp_add_issue.sv
// Scoreboard bench for fp_add_issue with a 5-cycle adder responder stub.
module tb_fp_add_issue;
  import fp_add_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_op = 1'b0;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_op;
  logic        add_en;
  logic        add_done_tick = 1'b0;
  logic        add_nan = 1'b0;
  logic        add_inf = 1'b0;
  logic [31:0] add_o = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_nan;
  logic        out_inf;
  logic        out_err;
  logic        busy;

  always #5 clk = ~clk;

  fp_add_issue #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_op         (in_op),
    .add_a         (add_a),
    .add_b         (add_b),
    .add_op        (add_op),
    .add_en        (add_en),
    .add_done_tick (add_done_tick),
    .add_nan       (add_nan),
    .add_inf       (add_inf),
    .add_o         (add_o),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_nan       (out_nan),
    .out_inf       (out_inf),
    .out_err       (out_err),
    .busy          (busy)
  );

  typedef struct {
    logic [31:0] res;
    logic        nan;
    logic        inf;
    logic        err;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [64:0] opq[$];
  int          n_en = 0;
  int          rst_cnt = 0;
  bit          stub_hang = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Hand-computed adder answers: {result, nan pulse mid-op, inf pulse with done}
  function automatic logic [33:0] fp_ref(input logic op, input logic [31:0] a, input logic [31:0] b);
    case ({op, a, b})
      {1'b0, 32'h3F800000, 32'h40000000}: return {32'h40400000, 2'b00};
      {1'b1, 32'h40400000, 32'h3F800000}: return {32'h40000000, 2'b00};
      {1'b0, 32'h7FC00000, 32'h3F800000}: return {32'h7FC00000, 2'b10};
      {1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF}: return {32'h7F800000, 2'b01};
      {1'b0, 32'h40A00000, 32'h3F800000}: return {32'h40C00000, 2'b00};
      {1'b0, 32'h40000000, 32'h40000000}: return {32'h40800000, 2'b00};
      {1'b1, 32'h41200000, 32'h40000000}: return {32'h41000000, 2'b00};
      {1'b1, 32'h3F800000, 32'h3F800000}: return {32'h00000000, 2'b00};
      {1'b0, 32'h3F800000, 32'h3F800000}: return {32'h40000000, 2'b00};
      default:                            return '0;
    endcase
  endfunction

  always @(negedge reset_n) rst_cnt++;

  // Adder stub: samples en on the LAUNCH edge, done_tick 5 edges later.
  initial begin : stub
    logic [64:0] want;
    logic [33:0] r;
    int          rc;
    bit          hang;
    forever begin
      @(negedge clk);
      if (add_en === 1'b1) begin
        n_en++;
        rc   = rst_cnt;
        hang = stub_hang;
        want = '0;
        if (opq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL launch_unexpected: got add_en=1 expected no launch (t=%0t)", $time);
        end else begin
          want = opq.pop_front();
          chk("launch_op", {31'b0, add_op}, {31'b0, want[64]});
          chk("launch_a", add_a, want[63:32]);
          chk("launch_b", add_b, want[31:0]);
        end
        r = fp_ref(want[64], want[63:32], want[31:0]);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
          @(posedge clk);
          #1;
          add_nan = (k == 2) && r[1] && !hang;
          if (k == 5 && !hang) begin
            add_done_tick = 1'b1;
            add_o         = r[33:2];
            add_inf       = r[0];
          end
        end
        @(posedge clk);
        #1;
        add_done_tick = 1'b0;
        add_inf       = 1'b0;
        add_nan       = 1'b0;
        add_o         = '0;
        if (rc == rst_cnt) chk("operands_stable", add_a ^ add_b, want[63:32] ^ want[31:0]);
      end
    end
  end

  // Monitor: compare every accepted result against the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_unexpected: got %h expected no result (t=%0t)", out_result, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_result", out_result, e.res);
          chk("out_nan", {31'b0, out_nan}, {31'b0, e.nan});
          chk("out_inf", {31'b0, out_inf}, {31'b0, e.inf});
          chk("out_err", {31'b0, out_err}, {31'b0, e.err});
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input logic [31:0] eres, input logic en, input logic ei, input logic ee,
                      input bit expect_out, output time t_acc);
    int guard = 0;
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    t_acc = $time;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 within 200 cycles");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      t_acc = $time;
      #1;
      in_valid = 1'b0;
      opq.push_back({op, a, b});
      if (expect_out) exp_q.push_back('{eres, en, ei, ee});
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL wait_idle: got busy=%b pending=%0d expected idle within %0d cycles", busy, exp_q.size(), max);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_add_en"}, {31'b0, add_en}, 32'd0);
    chk({tag, "_flags"}, {29'b0, out_nan, out_inf, out_err}, 32'd0);
    chk({tag, "_out_result"}, out_result, 32'd0);
    chk({tag, "_add_a"}, add_a, 32'd0);
    chk({tag, "_add_b"}, add_b, 32'd0);
    chk({tag, "_add_op"}, {31'b0, add_op}, 32'd0);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: got no finish expected finish by 500000");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    time t;
    int  e0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1.0 + 2.0, out_valid exactly 8 edges after the accepting edge
    push(32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b1, t);
    #(t + 75 - $time);
    chk("valid_t7", {31'b0, out_valid}, 32'd0);
    #10;
    chk("valid_t8", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    wait_idle(50);

    push(32'h40400000, 32'h3F800000, OP_SUB, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b1, t);
    push(32'h7FC00000, 32'h3F800000, OP_ADD, 32'h7FC00000, 1'b1, 1'b0, 1'b0, 1'b1, t);
    push(32'h7F7FFFFF, 32'h7F7FFFFF, OP_ADD, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b1, t);
    wait_idle(100);

    // Back-pressure: five pairs fill the FIFO behind one stalled op
    out_ready = 1'b0;
    e0 = n_en;
    push(32'h40A00000, 32'h3F800000, OP_ADD, 32'h40C00000, 1'b0, 1'b0, 1'b0, 1'b1, t);
    push(32'h40000000, 32'h40000000, OP_ADD, 32'h40800000, 1'b0, 1'b0, 1'b0, 1'b1, t);
    push(32'h41200000, 32'h40000000, OP_SUB, 32'h41000000, 1'b0, 1'b0, 1'b0, 1'b1, t);
    push(32'h3F800000, 32'h3F800000, OP_SUB, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, t);
    push(32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b1, t);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    in_a = 32'hDEADBEEF;
    in_b = 32'hDEADBEEF;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_result", out_result, 32'h40C00000);
      chk("hold_no_en", {31'b0, add_en}, 32'd0);
      chk("hold_busy", {31'b0, busy}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("single_launch", n_en - e0, 32'd1);
    out_ready = 1'b1;
    wait_idle(200);

`ifdef FP_ISSUE_TIMEOUT_EN
    stub_hang = 1'b1;
    push(32'h3F800000, 32'h3F800000, OP_ADD, FP32_QNAN, 1'b0, 1'b0, 1'b1, 1'b1, t);
    #(t + 175 - $time);
    chk("wd_valid_early", {31'b0, out_valid}, 32'd0);
    #10;
    chk("wd_valid", {31'b0, out_valid}, 32'd1);
    chk("wd_err", {31'b0, out_err}, 32'd1);
    chk("wd_result", out_result, FP32_QNAN);
    @(posedge clk);
    #1;
    stub_hang = 1'b0;
    wait_idle(50);
`else
    stub_hang = 1'b1;
    push(32'h3F800000, 32'h3F800000, OP_ADD, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, t);
    repeat (40) begin
      @(negedge clk);
      chk("no_wd_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("no_wd_err", {31'b0, out_err}, 32'd0);
    stub_hang = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
`endif

    // Reset while the adder is mid-operation
    push(32'h3F800000, 32'h3F800000, OP_ADD, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, t);
    #(t + 41 - $time);
    chk("pre_reset_busy", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("late_done_ignored_valid", {31'b0, out_valid}, 32'd0);
    chk("late_done_ignored_busy", {31'b0, busy}, 32'd0);
    push(32'h40000000, 32'h40000000, OP_ADD, 32'h40800000, 1'b0, 1'b0, 1'b0, 1'b1, t);
    wait_idle(50);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("launch_queue_empty", opq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
